// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt front-end: FSM state encoding and parameter defaults.
package int_controller_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_SVC  = 2'd2
    } ic_state_t;

    localparam int unsigned IC_N_IRQ_DEF  = 4;
    localparam int unsigned IC_VEC_W_DEF  = 2;
    localparam int unsigned IC_SYNC_DEF   = 2;

endpackage

// File: rtl/int_controller_irq_sync.sv
// Multi-stage synchroniser for the IRQ lines plus one history flop for rising-edge detection.
module irq_sync
    import int_controller_pkg::*;
#(
    parameter int unsigned N_IRQ       = IC_N_IRQ_DEF,
    parameter int unsigned SYNC_STAGES = IC_SYNC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    output logic [N_IRQ-1:0] irq_edge
);

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;
    logic [N_IRQ-1:0]                  r_sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // A held-high level yields exactly one edge pulse.
    assign irq_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/int_controller.sv
// Interrupt front-end: pending/mask registers, fixed lowest-index-first priority and a
// request/service FSM that holds one request until ack and blocks new ones until EOI.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int unsigned N_IRQ       = IC_N_IRQ_DEF,
    parameter int unsigned SYNC_STAGES = IC_SYNC_DEF,
    parameter int unsigned VEC_W       = IC_VEC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask
);

    ic_state_t        r_state, w_state_nxt;
    logic             r_req, w_req_nxt;
    logic [VEC_W-1:0] r_vec, w_vec_nxt;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_eligible;
    logic [N_IRQ-1:0] w_clr;
    logic [VEC_W-1:0] w_prio;
    logic             w_vec_masked;

    irq_sync #(
        .N_IRQ       (N_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .irq_edge (w_edge)
    );

    assign w_eligible = r_pending & ~r_mask;

    always_comb begin
        w_prio = '0;
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (w_eligible[i-1]) w_prio = VEC_W'(i - 1);
        end
    end

    // Withdrawal sees a mask write in the same cycle it is issued.
    assign w_vec_masked = mask_we ? mask_in[r_vec] : r_mask[r_vec];
    assign w_clr        = (r_state == IC_REQ && int_ack) ? (N_IRQ'(1) << r_vec) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_vec_nxt   = r_vec;
        unique case (r_state)
            IC_IDLE: begin
                w_req_nxt = 1'b0;
                if (|w_eligible) begin
                    w_state_nxt = IC_REQ;
                    w_req_nxt   = 1'b1;
                    w_vec_nxt   = w_prio;
                end
            end
            IC_REQ: begin
                if (int_ack) begin
                    w_state_nxt = IC_SVC;
                    w_req_nxt   = 1'b0;
                end else if (w_vec_masked) begin
                    w_state_nxt = IC_IDLE;
                    w_req_nxt   = 1'b0;
                end
            end
            IC_SVC: begin
                w_req_nxt = 1'b0;
                if (int_eoi) w_state_nxt = IC_IDLE;
            end
            default: begin
                w_state_nxt = IC_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IC_IDLE;
            r_req     <= 1'b0;
            r_vec     <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_vec     <= w_vec_nxt;
            // New edge wins over an ack clear on the same bit.
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) r_mask <= mask_in;
        end
    end

    assign int_req = r_req;
    assign int_vec = r_vec;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule
